id_ex_pipe: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS pipeline; the consumer side of the decode stage's control bundle.
- Captures decoded control, register operands and immediates each cycle and presents them to EX.
- Inserts load-use bubbles, holds EX for multi-cycle mul, and squashes on branch/jump flush.
- Drives the IF/ID stall back toward fetch/decode.

---
 rtl/pipe_pkg.sv | 55 +++++
 rtl/hazard_detect.sv | 25 ++
 rtl/id_ex_pipe.sv | 110 +++++++++++
 tb/tb_id_ex_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the ID/EX pipeline register.
// Control bundle layout, bubble constant and mul detection.
package pipe_pkg;

   localparam int CTRL_W = 20;

   typedef struct packed {
      logic [1:0] pc_src;
      logic       branch;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] mem_to_reg;
      logic       alu_src1;
      logic       alu_src2;
      logic       ext_op;
      logic       lu_op;
      logic [3:0] alu_op;
      logic [1:0] spare;
   } ctrl_t;

   localparam logic [2:0] ALUOP_MUL = 3'b110;

   localparam logic [1:0] MEMTOREG_ALU = 2'b00;
   localparam logic [1:0] MEMTOREG_MEM = 2'b01;
   localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

   localparam ctrl_t BUBBLE_CTRL = '0;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc4;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      ctrl_t       ctrl;
   } id_ex_t;

   localparam id_ex_t BUBBLE = '0;

   typedef enum logic {
      IDLE,
      MUL_HOLD
   } hold_state_t;

   function automatic logic is_mul(input ctrl_t c);
      return c.alu_op[2:0] == ALUOP_MUL;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check between the load in EX
// and the instruction currently in ID.
module hazard_detect (
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_alu_src2,
   input  logic       id_mem_write,
   output logic       load_use
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = id_rs == ex_rt;
   // rt is a source only for R-type ops and as store data
   assign rt_hit = (id_rt == ex_rt) & (~id_alu_src2 | id_mem_write);

   assign load_use = ex_valid & ex_mem_read & (ex_rt != 5'd0)
                   & id_valid & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubbles,
// multi-cycle mul hold and branch/jump flush.
module id_ex_pipe
   import pipe_pkg::*;
#(
   parameter int MUL_LAT = 3,
   parameter int CNT_W   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [31:0] id_pc4,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic [4:0]  id_shamt,
   input  logic [31:0] id_imm,
   input  logic [19:0] id_ctrl,
   input  logic        flush,
   output logic        ex_valid,
   output logic [31:0] ex_pc4,
   output logic [31:0] ex_rs_data,
   output logic [31:0] ex_rt_data,
   output logic [31:0] ex_imm,
   output logic [4:0]  ex_rs,
   output logic [4:0]  ex_rt,
   output logic [4:0]  ex_rd,
   output logic [4:0]  ex_shamt,
   output logic [19:0] ex_ctrl,
   output logic        stall_if_id,
   output logic        mul_busy
);

   id_ex_t      ex_q;
   id_ex_t      id_cap;
   hold_state_t state;
   logic [CNT_W-1:0] cnt;
   logic        load_use;
   logic        mul_start;

   // Live ID fields as they would be latched into EX
   always_comb begin
      id_cap         = BUBBLE;
      id_cap.valid   = id_valid;
      id_cap.pc4     = id_pc4;
      id_cap.rs_data = id_rs_data;
      id_cap.rt_data = id_rt_data;
      id_cap.imm     = id_imm;
      id_cap.rs      = id_rs;
      id_cap.rt      = id_rt;
      id_cap.rd      = id_rd;
      id_cap.shamt   = id_shamt;
      id_cap.ctrl    = ctrl_t'(id_ctrl);
   end

   hazard_detect u_hazard (
      .ex_valid     (ex_q.valid),
      .ex_mem_read  (ex_q.ctrl.mem_read),
      .ex_rt        (ex_q.rt),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_alu_src2  (id_cap.ctrl.alu_src2),
      .id_mem_write (id_cap.ctrl.mem_write),
      .load_use     (load_use)
   );

   assign mul_start = id_valid & is_mul(id_cap.ctrl) & (MUL_LAT > 1);

   // EX register and mul hold FSM; flush beats hold beats bubble
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q  <= BUBBLE;
         cnt   <= '0;
         state <= IDLE;
      end else if (flush) begin
         ex_q  <= BUBBLE;
         cnt   <= '0;
         state <= IDLE;
      end else if (state == MUL_HOLD) begin
         cnt <= cnt - 1'b1;
         if (cnt == CNT_W'(1)) state <= IDLE;
      end else if (load_use) begin
         ex_q <= BUBBLE;
      end else begin
         ex_q <= id_cap;
         if (mul_start) begin
            cnt   <= CNT_W'(MUL_LAT - 1);
            state <= MUL_HOLD;
         end
      end
   end

   assign mul_busy    = state == MUL_HOLD;
   assign stall_if_id = ~flush & (mul_busy | load_use);

   assign ex_valid   = ex_q.valid;
   assign ex_pc4     = ex_q.pc4;
   assign ex_rs_data = ex_q.rs_data;
   assign ex_rt_data = ex_q.rt_data;
   assign ex_imm     = ex_q.imm;
   assign ex_rs      = ex_q.rs;
   assign ex_rt      = ex_q.rt;
   assign ex_rd      = ex_q.rd;
   assign ex_shamt   = ex_q.shamt;
   assign ex_ctrl    = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed table, reset
// mid-hold, and randomized run against a model.
module tb_id_ex_pipe;

   localparam int MUL_LAT = 3;
   localparam int CNT_W   = 2;

   // RegWrite=16 RegDst=15:14 MemRead=13 MemWrite=12
   // MemtoReg=11:10 ALUSrc2=8 ExtOp=7 ALUOp=5:2
   localparam logic [19:0] C_LW   = 20'h12580;
   localparam logic [19:0] C_ADD  = 20'h14008;
   localparam logic [19:0] C_MUL  = 20'h14018;
   localparam logic [19:0] C_SW   = 20'h01180;
   localparam logic [19:0] C_ADDI = 20'h10180;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid, flush;
   logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
   logic [19:0] id_ctrl;
   logic        ex_valid;
   logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
   logic [19:0] ex_ctrl;
   logic        stall_if_id, mul_busy;

   always #5 clk = ~clk;

   id_ex_pipe #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_pc4(id_pc4),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_shamt(id_shamt), .id_imm(id_imm),
      .id_ctrl(id_ctrl), .flush(flush),
      .ex_valid(ex_valid), .ex_pc4(ex_pc4),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_rd(ex_rd), .ex_shamt(ex_shamt),
      .ex_ctrl(ex_ctrl), .stall_if_id(stall_if_id),
      .mul_busy(mul_busy)
   );

   typedef struct packed {
      logic        flush;
      logic        valid;
      logic [31:0] pc4, rs_data, rt_data, imm;
      logic [4:0]  rs, rt, rd, shamt;
      logic [19:0] ctrl;
   } in_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc4, rs_data, rt_data, imm;
      logic [4:0]  rs, rt, rd, shamt;
      logic [19:0] ctrl;
   } ex_t;

   typedef struct {
      in_t        in;
      logic       e_stall;
      logic       e_busy;
      logic       e_valid;
      logic [4:0] e_rd;
   } row_t;

   int   checks = 0;
   int   failures = 0;
   ex_t  m_ex;
   int   m_hold;
   row_t tbl[$];

   function automatic ex_t dut_ex();
      return {ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
              ex_rs, ex_rt, ex_rd, ex_shamt, ex_ctrl};
   endfunction

   function automatic ex_t to_ex(input in_t i);
      return {i.valid, i.pc4, i.rs_data, i.rt_data, i.imm,
              i.rs, i.rt, i.rd, i.shamt, i.ctrl};
   endfunction

   // Load in EX whose destination is read by the ID instruction
   function automatic logic model_lu(input in_t i);
      logic reads_rt;
      reads_rt = !i.ctrl[8] || i.ctrl[12];
      return m_ex.valid && m_ex.ctrl[13] && m_ex.rt != 0 && i.valid
          && (i.rs == m_ex.rt || (i.rt == m_ex.rt && reads_rt));
   endfunction

   function automatic in_t mk(input logic fl, input logic v,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [19:0] c);
      in_t i;
      i.flush   = fl;
      i.valid   = v;
      i.pc4     = 32'h0040_0000 + 32'(rd) * 4;
      i.rs_data = 32'h1000_0000 | 32'(rd);
      i.rt_data = 32'h2000_0000 | 32'(rd);
      i.imm     = 32'(rd) * 7;
      i.rs      = rs;
      i.rt      = rt;
      i.rd      = rd;
      i.shamt   = rd ^ 5'h3;
      i.ctrl    = c;
      return i;
   endfunction

   task automatic row(input logic fl, input logic v,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [19:0] c,
                      input logic es, input logic eb,
                      input logic ev, input logic [4:0] erd);
      row_t r;
      r.in = mk(fl, v, rs, rt, rd, c);
      r.e_stall = es;
      r.e_busy  = eb;
      r.e_valid = ev;
      r.e_rd    = erd;
      tbl.push_back(r);
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_ex(input string name, input ex_t act, input ex_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input in_t i);
      flush      = i.flush;
      id_valid   = i.valid;
      id_pc4     = i.pc4;
      id_rs_data = i.rs_data;
      id_rt_data = i.rt_data;
      id_imm     = i.imm;
      id_rs      = i.rs;
      id_rt      = i.rt;
      id_rd      = i.rd;
      id_shamt   = i.shamt;
      id_ctrl    = i.ctrl;
   endtask

   // One cycle: called just after a rising edge
   task automatic step(input in_t i, output logic o_stall,
                       output logic o_busy);
      logic lu;
      drive(i);
      #2;
      lu = model_lu(i);
      o_stall = stall_if_id;
      o_busy  = mul_busy;
      chk("stall_if_id", 32'(stall_if_id),
          32'(!i.flush && (m_hold > 0 || lu)));
      chk("mul_busy", 32'(mul_busy), 32'(m_hold > 0));
      @(posedge clk);
      if (i.flush) begin
         m_ex = '0;
         m_hold = 0;
      end else if (m_hold > 0) begin
         m_hold--;
      end else if (lu) begin
         m_ex = '0;
      end else begin
         m_ex = to_ex(i);
         if (i.valid && i.ctrl[4:2] == 3'b110 && MUL_LAT > 1)
            m_hold = MUL_LAT - 1;
      end
      #1;
      chk_ex("ex_regs", dut_ex(), m_ex);
   endtask

   initial begin
      logic s, b;
      in_t  ri;

      //  fl v  rs  rt  rd  ctrl    stall busy ev erd
      row(0, 1, 1,  8,  11, C_LW,   0, 0, 1, 11);
      row(0, 1, 8,  10, 9,  C_ADD,  1, 0, 0, 0);
      row(0, 1, 8,  10, 9,  C_ADD,  0, 0, 1, 9);
      row(0, 1, 1,  8,  12, C_LW,   0, 0, 1, 12);
      row(0, 1, 8,  9,  13, C_LW,   1, 0, 0, 0);
      row(0, 1, 8,  9,  13, C_LW,   0, 0, 1, 13);
      row(0, 1, 1,  0,  14, C_LW,   0, 0, 1, 14);
      row(0, 1, 0,  0,  15, C_ADD,  0, 0, 1, 15);
      row(0, 1, 3,  4,  16, C_MUL,  0, 0, 1, 16);
      row(0, 1, 5,  6,  17, C_ADD,  1, 1, 1, 16);
      row(0, 1, 5,  6,  17, C_ADD,  1, 1, 1, 16);
      row(0, 1, 5,  6,  17, C_ADD,  0, 0, 1, 17);
      row(0, 1, 3,  4,  18, C_MUL,  0, 0, 1, 18);
      row(1, 1, 5,  6,  19, C_ADD,  0, 1, 0, 0);
      row(0, 1, 5,  6,  19, C_ADD,  0, 0, 1, 19);
      row(0, 1, 1,  8,  20, C_LW,   0, 0, 1, 20);
      row(1, 1, 8,  10, 21, C_ADD,  0, 0, 0, 0);
      row(0, 0, 0,  0,  0,  20'h0,  0, 0, 0, 0);
      row(0, 1, 1,  8,  22, C_LW,   0, 0, 1, 22);
      row(0, 1, 2,  8,  24, C_SW,   1, 0, 0, 0);
      row(0, 1, 2,  8,  24, C_SW,   0, 0, 1, 24);
      row(0, 1, 1,  8,  25, C_LW,   0, 0, 1, 25);
      row(0, 1, 2,  8,  26, C_ADDI, 0, 0, 1, 26);

      m_ex = '0;
      m_hold = 0;
      reset = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 20'h0));
      @(posedge clk);
      #1;
      chk_ex("reset_ex", dut_ex(), '0);
      chk("reset_busy", 32'(mul_busy), 32'd0);
      reset = 1'b0;

      foreach (tbl[k]) begin
         step(tbl[k].in, s, b);
         chk($sformatf("tbl%0d_stall", k), 32'(s), 32'(tbl[k].e_stall));
         chk($sformatf("tbl%0d_busy", k), 32'(b), 32'(tbl[k].e_busy));
         chk($sformatf("tbl%0d_valid", k), 32'(ex_valid),
             32'(tbl[k].e_valid));
         chk($sformatf("tbl%0d_rd", k), 32'(ex_rd), 32'(tbl[k].e_rd));
      end

      // Reset in the middle of a mul hold, between clock edges
      step(mk(0, 1, 3, 4, 27, C_MUL), s, b);
      drive(mk(0, 0, 0, 0, 0, 20'h0));
      #2;
      chk("pre_reset_valid", 32'(ex_valid), 32'd1);
      chk("pre_reset_busy", 32'(mul_busy), 32'd1);
      reset = 1'b1;
      #1;
      chk_ex("async_reset_ex", dut_ex(), '0);
      chk("async_reset_busy", 32'(mul_busy), 32'd0);
      chk("async_reset_stall", 32'(stall_if_id), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_ex = '0;
      m_hold = 0;

      for (int n = 0; n < 600; n++) begin
         ri.flush   = $urandom_range(0, 9) == 0;
         ri.valid   = $urandom_range(0, 4) != 0;
         ri.pc4     = $urandom();
         ri.rs_data = $urandom();
         ri.rt_data = $urandom();
         ri.imm     = $urandom();
         ri.rs      = 5'($urandom_range(0, 3));
         ri.rt      = 5'($urandom_range(0, 3));
         ri.rd      = 5'($urandom());
         ri.shamt   = 5'($urandom());
         case ($urandom_range(0, 5))
            0: ri.ctrl = C_LW;
            1: ri.ctrl = C_ADD;
            2: ri.ctrl = C_MUL;
            3: ri.ctrl = C_SW;
            4: ri.ctrl = C_ADDI;
            default: ri.ctrl = 20'($urandom());
         endcase
         step(ri, s, b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
